// File: rtl/regfile_sb.sv
// MIPS register file: combinational read ports with optional write-back bypass,
// per-register pending-write scoreboard, and HI/LO with a mult/div busy bit.
module regfile_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2,
   parameter int BYPASS = 1,
   parameter int CNT_W  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic                     issue_valid,
   input  logic [ADDR_W-1:0]        issue_addr,
   output logic                     issue_ready,
   input  logic                     hilo_issue,
   output logic                     hilo_ready,
   input  logic                     hi_we,
   input  logic                     lo_we,
   input  logic [DATA_W-1:0]        hi_in,
   input  logic [DATA_W-1:0]        lo_in,
   output logic [DATA_W-1:0]        hi_out,
   output logic [DATA_W-1:0]        lo_out,
   output logic                     hilo_busy
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [DEPTH-1:0][DATA_W-1:0]  regs_q, regs_d;
   logic [DEPTH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]             hi_q, hi_d, lo_q, lo_d;
   logic                          hilo_busy_q, hilo_busy_d;

   logic [NUM_WR-1:0][ADDR_W-1:0] wa;
   logic [NUM_WR-1:0][DATA_W-1:0] wd;
   logic [NUM_RD-1:0][ADDR_W-1:0] ra;
   logic [NUM_RD-1:0][DATA_W-1:0] rdat;
   logic [NUM_RD-1:0]             rbusy;

   logic issue_wb_hit;
   logic issue_acc;
   logic hilo_done;
   logic hilo_acc;
   int   cnt_tmp;
   int   rd_match;

   assign wa      = wr_addr;
   assign wd      = wr_data;
   assign ra      = rd_addr;
   assign rd_data = rdat;
   assign rd_busy = rbusy;

   // A write-back landing this cycle frees a slot, so a saturated register can still accept.
   always_comb begin
      issue_wb_hit = 1'b0;
      for (int w = 0; w < NUM_WR; w++)
         if (wr_en[w] && wa[w] == issue_addr) issue_wb_hit = 1'b1;
   end

   assign issue_ready = (issue_addr == '0) || (cnt_q[issue_addr] != CNT_MAX) || issue_wb_hit;
   assign issue_acc   = issue_valid && issue_ready && (issue_addr != '0);

   // Register 0 is skipped: it keeps its reset value and never counts.
   always_comb begin
      regs_d  = regs_q;
      cnt_d   = cnt_q;
      cnt_tmp = 0;
      for (int r = 1; r < DEPTH; r++) begin
         cnt_tmp = int'(cnt_q[r]);
         if (issue_acc && issue_addr == ADDR_W'(r)) cnt_tmp = cnt_tmp + 1;
         for (int w = 0; w < NUM_WR; w++)
            if (wr_en[w] && wa[w] == ADDR_W'(r)) begin
               regs_d[r] = wd[w];
               cnt_tmp   = cnt_tmp - 1;
            end
         cnt_d[r] = (cnt_tmp < 0) ? '0 : CNT_W'(cnt_tmp);
      end
   end

   always_comb begin
      rdat     = '0;
      rbusy    = '0;
      rd_match = 0;
      for (int p = 0; p < NUM_RD; p++) begin
         rd_match = 0;
         rdat[p]  = regs_q[ra[p]];
         if (BYPASS != 0)
            for (int w = 0; w < NUM_WR; w++)
               if (wr_en[w] && wa[w] == ra[p]) begin
                  rdat[p]  = wd[w];
                  rd_match = rd_match + 1;
               end
         if (ra[p] == '0) rdat[p] = '0;
         rbusy[p] = (ra[p] != '0) && (int'(cnt_q[ra[p]]) > rd_match);
      end
   end

   // Completion and a new issue in the same cycle hand the busy bit straight over.
   assign hilo_done   = hi_we && lo_we;
   assign hilo_ready  = !hilo_busy_q || hilo_done;
   assign hilo_acc    = hilo_issue && hilo_ready;
   assign hilo_busy_d = hilo_acc || (hilo_busy_q && !hilo_done);
   assign hi_d        = hi_we ? hi_in : hi_q;
   assign lo_d        = lo_we ? lo_in : lo_q;

   assign hi_out    = hi_q;
   assign lo_out    = lo_q;
   assign hilo_busy = hilo_busy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q      <= '0;
         cnt_q       <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         hilo_busy_q <= 1'b0;
      end else begin
         regs_q      <= regs_d;
         cnt_q       <= cnt_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         hilo_busy_q <= hilo_busy_d;
      end
   end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios with literal expectations plus a
// per-cycle compare of a bypassing and a non-bypassing instance against a model.
module tb_regfile_sb;
   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data, rd_data_nb;
   logic [1:0]  rd_busy, rd_busy_nb;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        issue_valid;
   logic [4:0]  issue_addr;
   logic        issue_ready, issue_ready_nb;
   logic        hilo_issue;
   logic        hilo_ready, hilo_ready_nb;
   logic        hi_we, lo_we;
   logic [31:0] hi_in, lo_in;
   logic [31:0] hi_out, lo_out, hi_out_nb, lo_out_nb;
   logic        hilo_busy, hilo_busy_nb;

   int nvec = 0;
   int nerr = 0;
   bit cmp_en = 1'b0;

   logic [31:0] mreg [32];
   int          mcnt [32];
   logic [31:0] mhi, mlo;
   bit          mhb;

   always #5 clk = ~clk;

   regfile_sb #(.BYPASS(1)) dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
      .hilo_issue(hilo_issue), .hilo_ready(hilo_ready), .hi_we(hi_we), .lo_we(lo_we),
      .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out), .lo_out(lo_out), .hilo_busy(hilo_busy));

   regfile_sb #(.BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready_nb),
      .hilo_issue(hilo_issue), .hilo_ready(hilo_ready_nb), .hi_we(hi_we), .lo_we(lo_we),
      .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out_nb), .lo_out(lo_out_nb),
      .hilo_busy(hilo_busy_nb));

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(string nm, logic act, logic exp);
      chk(nm, {31'd0, act}, {31'd0, exp});
   endtask

   // ---------------- reference model ----------------
   function automatic int hits_on(logic [4:0] a);
      int h = 0;
      for (int w = 0; w < 2; w++)
         if (wr_en[w] && wr_addr[w*5 +: 5] == a) h++;
      return h;
   endfunction

   function automatic bit exp_iready();
      return (issue_addr == 5'd0) || (mcnt[issue_addr] != 3) || (hits_on(issue_addr) > 0);
   endfunction

   function automatic logic [31:0] exp_rdata(bit byp, int p);
      logic [4:0]  a;
      logic [31:0] d;
      a = rd_addr[p*5 +: 5];
      if (a == 5'd0) return 32'd0;
      d = mreg[a];
      if (byp)
         for (int w = 0; w < 2; w++)
            if (wr_en[w] && wr_addr[w*5 +: 5] == a) d = wr_data[w*32 +: 32];
      return d;
   endfunction

   function automatic bit exp_rbusy(bit byp, int p);
      logic [4:0] a;
      int         pend;
      a = rd_addr[p*5 +: 5];
      if (a == 5'd0) return 1'b0;
      pend = mcnt[a] - (byp ? hits_on(a) : 0);
      return pend > 0;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         mreg[r] = 32'd0;
         mcnt[r] = 0;
      end
      mhi = 32'd0;
      mlo = 32'd0;
      mhb = 1'b0;
   endtask

   task automatic model_step();
      bit acc, hdone, hacc;
      int n;
      acc   = issue_valid && exp_iready() && (issue_addr != 5'd0);
      hdone = hi_we && lo_we;
      hacc  = hilo_issue && (!mhb || hdone);
      for (int r = 1; r < 32; r++) begin
         n = mcnt[r] - hits_on(5'(r));
         if (acc && issue_addr == 5'(r)) n++;
         if (n < 0) n = 0;
         mcnt[r] = n;
         for (int w = 0; w < 2; w++)
            if (wr_en[w] && wr_addr[w*5 +: 5] == 5'(r)) mreg[r] = wr_data[w*32 +: 32];
      end
      if (hi_we) mhi = hi_in;
      if (lo_we) mlo = lo_in;
      if (hacc) mhb = 1'b1;
      else if (hdone) mhb = 1'b0;
   endtask

   always @(negedge clk) begin
      if (cmp_en && !rst) begin
         for (int p = 0; p < 2; p++) begin
            chk("rd_data", rd_data[p*32 +: 32], exp_rdata(1'b1, p));
            chk1("rd_busy", rd_busy[p], exp_rbusy(1'b1, p));
            chk("rd_data_nb", rd_data_nb[p*32 +: 32], exp_rdata(1'b0, p));
            chk1("rd_busy_nb", rd_busy_nb[p], exp_rbusy(1'b0, p));
         end
         chk1("issue_ready", issue_ready, exp_iready());
         chk1("issue_ready_nb", issue_ready_nb, exp_iready());
         chk1("hilo_ready", hilo_ready, !mhb || (hi_we && lo_we));
         chk1("hilo_busy", hilo_busy, mhb);
         chk("hi_out", hi_out, mhi);
         chk("lo_out", lo_out, mlo);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      wr_en       = 2'b00;
      issue_valid = 1'b0;
      hilo_issue  = 1'b0;
      hi_we       = 1'b0;
      lo_we       = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      if (!rst) model_step();
      #1;
      idle();
   endtask

   initial begin
      int ip, wp, hr;
      rst = 1'b1;
      idle();
      rd_addr = '0; wr_addr = '0; wr_data = '0; issue_addr = '0;
      hi_in = '0; lo_in = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      cmp_en = 1'b1;
      #1;
      chk1("rst_issue_ready", issue_ready, 1'b1);
      chk1("rst_hilo_ready", hilo_ready, 1'b1);
      chk1("rst_hilo_busy", hilo_busy, 1'b0);
      chk("rst_hi_out", hi_out, 32'd0);
      chk("rst_lo_out", lo_out, 32'd0);

      // all registers read zero and idle on every port after reset
      for (int a = 0; a < 32; a++) begin
         rd_addr = {5'(a), 5'(a)};
         #1;
         chk("rst_rd0", rd_data[31:0], 32'd0);
         chk("rst_rd1", rd_data[63:32], 32'd0);
         chk("rst_rd0_nb", rd_data_nb[31:0], 32'd0);
         chk1("rst_busy0", rd_busy[0], 1'b0);
         chk1("rst_busy1", rd_busy[1], 1'b0);
         cyc();
      end

      // dual write to r5: higher port wins
      wr_en   = 2'b11;
      wr_addr = {5'd5, 5'd5};
      wr_data = {32'h0000BEEF, 32'h00001234};
      rd_addr = {5'd5, 5'd5};
      #1;
      chk("t2_bypass_same", rd_data[31:0], 32'h0000BEEF);
      chk("t2_nobypass_same", rd_data_nb[31:0], 32'd0);
      cyc();
      #1;
      chk("t2_bypass_next", rd_data[63:32], 32'h0000BEEF);
      chk("t2_nobypass_next", rd_data_nb[31:0], 32'h0000BEEF);

      // saturate r7, then a write-back lets the 4th issue through
      rd_addr = {5'd0, 5'd7};
      for (int k = 0; k < 3; k++) begin
         issue_valid = 1'b1;
         issue_addr  = 5'd7;
         #1;
         chk1("t3_issue_ok", issue_ready, 1'b1);
         cyc();
      end
      #1;
      chk1("t3_busy", rd_busy[0], 1'b1);
      chk1("t3_busy_nb", rd_busy_nb[0], 1'b1);
      issue_valid = 1'b1;
      issue_addr  = 5'd7;
      #1;
      chk1("t3_issue_full", issue_ready, 1'b0);
      chk1("t3_issue_full_nb", issue_ready_nb, 1'b0);
      cyc();
      issue_valid = 1'b1;
      issue_addr  = 5'd7;
      wr_en       = 2'b01;
      wr_addr     = {5'd0, 5'd7};
      wr_data     = {32'd0, 32'h70};
      #1;
      chk1("t3_issue_wb", issue_ready, 1'b1);
      chk1("t3_busy_wb", rd_busy[0], 1'b1);
      cyc();
      for (int k = 0; k < 3; k++) begin
         wr_en   = 2'b01;
         wr_addr = {5'd0, 5'd7};
         wr_data = {32'd0, 32'h71 + 32'(k)};
         #1;
         if (k == 2) begin
            chk1("t3_last_wb_byp", rd_busy[0], 1'b0);
            chk1("t3_last_wb_nb", rd_busy_nb[0], 1'b1);
            chk("t3_last_wb_data", rd_data[31:0], 32'h73);
         end
         cyc();
      end
      #1;
      chk1("t3_drained", rd_busy[0], 1'b0);
      chk1("t3_drained_nb", rd_busy_nb[0], 1'b0);
      chk("t3_data_nb", rd_data_nb[31:0], 32'h73);

      // r0: always ready, never written, never busy
      issue_valid = 1'b1;
      issue_addr  = 5'd0;
      wr_en       = 2'b01;
      wr_addr     = '0;
      wr_data     = {32'd0, 32'h0000FFFF};
      rd_addr     = '0;
      #1;
      chk1("t4_issue_r0", issue_ready, 1'b1);
      chk("t4_rd_r0", rd_data[31:0], 32'd0);
      chk1("t4_busy_r0", rd_busy[0], 1'b0);
      cyc();
      #1;
      chk("t4_rd_r0_next", rd_data_nb[31:0], 32'd0);
      chk1("t4_busy_r0_next", rd_busy[0], 1'b0);

      // HI/LO scoreboard
      hilo_issue = 1'b1;
      #1;
      chk1("t5_hilo_ready0", hilo_ready, 1'b1);
      cyc();
      #1;
      chk1("t5_busy_set", hilo_busy, 1'b1);
      hilo_issue = 1'b1;
      #1;
      chk1("t5_second_issue", hilo_ready, 1'b0);
      cyc();
      hi_we = 1'b1;
      hi_in = 32'h9;
      #1;
      chk1("t5_hi_only_ready", hilo_ready, 1'b0);
      cyc();
      #1;
      chk1("t5_hi_only_busy", hilo_busy, 1'b1);
      chk("t5_hi_9", hi_out, 32'h9);
      hi_we = 1'b1; lo_we = 1'b1;
      hi_in = 32'h1; lo_in = 32'h2;
      #1;
      chk1("t5_done_ready", hilo_ready, 1'b1);
      chk("t5_hi_not_bypassed", hi_out, 32'h9);
      cyc();
      #1;
      chk1("t5_busy_clear", hilo_busy, 1'b0);
      chk("t5_hi_1", hi_out, 32'h1);
      chk("t5_lo_2", lo_out, 32'h2);
      hilo_issue = 1'b1;
      cyc();
      hilo_issue = 1'b1; hi_we = 1'b1; lo_we = 1'b1;
      hi_in = 32'h5; lo_in = 32'h6;
      #1;
      chk1("t5_overlap_ready", hilo_ready, 1'b1);
      cyc();
      #1;
      chk1("t5_overlap_busy", hilo_busy, 1'b1);
      hi_we = 1'b1; lo_we = 1'b1;
      cyc();
      #1;
      chk1("t5_overlap_clear", hilo_busy, 1'b0);

      // asynchronous reset between edges
      wr_en       = 2'b01;
      wr_addr     = {5'd0, 5'd3};
      wr_data     = {32'd0, 32'hAA};
      issue_valid = 1'b1;
      issue_addr  = 5'd4;
      cyc();
      rd_addr = {5'd4, 5'd3};
      #1;
      chk("t1_pre_rst_data", rd_data[31:0], 32'hAA);
      chk1("t1_pre_rst_busy", rd_busy[1], 1'b1);
      rst = 1'b1;
      model_reset();
      #1;
      chk("t1_async_data", rd_data[31:0], 32'd0);
      chk("t1_async_data_nb", rd_data_nb[31:0], 32'd0);
      chk1("t1_async_busy", rd_busy[1], 1'b0);
      chk("t1_async_hi", hi_out, 32'd0);
      chk("t1_async_lo", lo_out, 32'd0);
      rst = 1'b0;
      cyc();

      // random stream: issue-heavy first half, write-heavy second half
      for (int i = 0; i < 10000; i++) begin
         ip = (i < 5000) ? 70 : 30;
         wp = (i < 5000) ? 20 : 45;
         rd_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         wr_en[0]    = ($urandom_range(0, 99) < wp);
         wr_en[1]    = ($urandom_range(0, 99) < wp);
         wr_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         wr_data     = {$urandom, $urandom};
         issue_valid = ($urandom_range(0, 99) < ip);
         issue_addr  = 5'($urandom_range(0, 7));
         hilo_issue  = ($urandom_range(0, 99) < 30);
         hr          = int'($urandom_range(0, 99));
         hi_we       = (hr < 30);
         lo_we       = (hr < 20) || (hr >= 90);
         hi_in       = $urandom;
         lo_in       = $urandom;
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
